// File: rtl/ppi_hs_pkg.sv
// ppi_hs_pkg: shared constants for the multi-port handshake PPI.
//   - Control register bit positions and reset value.
//   - STATUS bit offsets within each 4-bit per-port nibble.
//   - BSR (bit set/reset) write field positions.
//   - Address map helpers, expressed as functions of the port count N.
package ppi_hs_pkg;

    // Control register: [0] dir (1 = input), [1] mode (1 = strobed), [2] inte
    localparam int          CTL_W     = 3;
    localparam int          CTL_DIR   = 0;
    localparam int          CTL_MODE  = 1;
    localparam int          CTL_INTE  = 2;
    localparam logic [2:0]  CTL_RESET = 3'b001;

    // STATUS layout: port p occupies bits [4p +: 4]
    localparam int ST_PER_PORT = 4;
    localparam int ST_IBF      = 0;
    localparam int ST_OBF      = 1;
    localparam int ST_INTR     = 2;
    localparam int ST_OVR      = 3;

    // BSR write: data[0] = value, data[4:1] = bit index, data[7:5] = port
    localparam int BSR_VAL      = 0;
    localparam int BSR_BIT_LSB  = 1;
    localparam int BSR_BIT_W    = 4;
    localparam int BSR_PORT_LSB = 5;
    localparam int BSR_PORT_W   = 3;

    function automatic int addr_data(input int p);
        return p;
    endfunction

    function automatic int addr_ctl(input int n, input int p);
        return n + p;
    endfunction

    function automatic int addr_status(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/ppi_port.sv
// ppi_port: one port of the PPI.
//   Holds the control register, data latch, registered pin sample,
//   stb_n/ack_n synchronisers with edge detection, and the mode-1
//   handshake state (ibf, obf_n, intr, ovr).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   pin               port input pins
//   stb_n, ack_n      asynchronous handshake lines (active-low)
//   ctl_we/ctl_wdata  control register write strobe/data
//   data_we/data_wdata data register write strobe/data
//   bsr_we/bsr_bit/bsr_val  single-bit latch modify (already range-checked)
//   rd_start, rd_end  data-register read start / rd_n rise for this port
//   ovr_clr           STATUS read finished: clear ovr
//   ctl, rd_data      control register and data read value
//   pd_o, pd_oe       port output value and enable
//   ibf, obf_n, intr, ovr  handshake status
module ppi_port
    import ppi_hs_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [W-1:0]         pin,
    input  logic                 stb_n,
    input  logic                 ack_n,
    input  logic                 ctl_we,
    input  logic [CTL_W-1:0]     ctl_wdata,
    input  logic                 data_we,
    input  logic [W-1:0]         data_wdata,
    input  logic                 bsr_we,
    input  logic [BSR_BIT_W-1:0] bsr_bit,
    input  logic                 bsr_val,
    input  logic                 rd_start,
    input  logic                 rd_end,
    input  logic                 ovr_clr,
    output logic [CTL_W-1:0]     ctl,
    output logic [W-1:0]         rd_data,
    output logic [W-1:0]         pd_o,
    output logic                 pd_oe,
    output logic                 ibf,
    output logic                 obf_n,
    output logic                 intr,
    output logic                 ovr
);

    logic         stb_s1, stb_s2, stb_q;
    logic         ack_s1, ack_s2, ack_q;
    logic [W-1:0] latch, pin_q;
    logic         dir, mode, inte;
    logic         m1_in, m1_out;
    logic         stb_fall, stb_rise, ack_fall, ack_rise;

    logic [CTL_W-1:0] ctl_d;
    logic [W-1:0]     latch_d;
    logic             ibf_d, obf_n_d, intr_d, ovr_d;

    assign dir    = ctl[CTL_DIR];
    assign mode   = ctl[CTL_MODE];
    assign inte   = ctl[CTL_INTE];
    assign m1_in  = dir & mode;
    assign m1_out = ~dir & mode;

    // Edges are taken between the second sync stage and the edge flop, so a
    // change first sampled on edge 1 acts on edge 3.
    assign stb_fall = stb_q & ~stb_s2;
    assign stb_rise = ~stb_q & stb_s2;
    assign ack_fall = ack_q & ~ack_s2;
    assign ack_rise = ~ack_q & ack_s2;

    assign rd_data = (dir & ~mode) ? pin_q : latch;
    assign pd_o    = latch;
    assign pd_oe   = ~dir;

    always_comb begin
        ctl_d   = ctl;
        latch_d = latch;
        ibf_d   = ibf;
        obf_n_d = obf_n;
        intr_d  = intr;
        ovr_d   = ovr;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        if (ctl_we) begin
            // A control write overrides any handshake event in the same cycle.
            ctl_d   = ctl_wdata;
            latch_d = '0;
            ibf_d   = 1'b0;
            obf_n_d = 1'b1;
            intr_d  = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (m1_in) begin
                if (rd_start) intr_d = 1'b0;
                if (rd_end)   ibf_d  = 1'b0;
                // Tested against ibf_d so a same-cycle read clear lets the
                // new strobe latch its data.
                if (stb_fall) begin
                    if (ibf_d) begin
                        ovr_d = 1'b1;
                    end else begin
                        latch_d = pin;
                        ibf_d   = 1'b1;
                    end
                end
                if (stb_rise && ibf && inte) intr_d = 1'b1;
            end
            if (!dir && data_we) begin
                latch_d = data_wdata;
                if (mode) begin
                    // A write beats a same-cycle ACK fall: obf_n stays low.
                    if (!obf_n) ovr_d = 1'b1;
                    obf_n_d = 1'b0;
                    intr_d  = 1'b0;
                end
            end else if (m1_out) begin
                if (ack_fall)         obf_n_d = 1'b1;
                if (ack_rise && inte) intr_d  = 1'b1;
            end
            if (bsr_we && !dir) begin
                for (int i = 0; i < W; i++) begin
                    if (int'(bsr_bit) == i) latch_d[i] = bsr_val;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stb_s1 <= 1'b1;
            stb_s2 <= 1'b1;
            stb_q  <= 1'b1;
            ack_s1 <= 1'b1;
            ack_s2 <= 1'b1;
            ack_q  <= 1'b1;
            ctl    <= CTL_RESET;
            latch  <= '0;
            pin_q  <= '0;
            ibf    <= 1'b0;
            obf_n  <= 1'b1;
            intr   <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            stb_s1 <= stb_n;
            stb_s2 <= stb_s1;
            stb_q  <= stb_s2;
            ack_s1 <= ack_n;
            ack_s2 <= ack_s1;
            ack_q  <= ack_s2;
            ctl    <= ctl_d;
            latch  <= latch_d;
            pin_q  <= pin;
            ibf    <= ibf_d;
            obf_n  <= obf_n_d;
            intr   <= intr_d;
            ovr    <= ovr_d;
        end
    end

endmodule

// File: rtl/ppi_hs.sv
// ppi_hs: N-port, W-bit programmable peripheral interface with mode-0
// latched I/O and mode-1 strobed I/O (STB/IBF, OBF/ACK, interrupt).
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   cs_n, rd_n, wr_n        CPU bus strobes, active-low, synchronous to clk
//   addr, data_in           register address, write data
//   data_out, data_oe       read data and its drive enable
//   pd_i, pd_o, pd_oe       port pins in / out / per-port output enable
//   stb_n, ibf              per-port input strobe / input buffer full
//   ack_n, obf_n            per-port output acknowledge / output buffer full
//   intr                    per-port interrupt
// Bus protocol: a write is a single event on the first clk edge that sees
// cs_n=0, wr_n=0 with the previous wr_n sample high. A read is the
// interval cs_n=0, rd_n=0, wr_n=1; its side effects happen on the edge that
// detects rd_n falling (read start) and the edge that detects rd_n rising
// (read end), both only while cs_n=0.
module ppi_hs
    import ppi_hs_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 2,
    parameter int AW = $clog2(2*N+1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cs_n,
    input  logic           rd_n,
    input  logic           wr_n,
    input  logic [AW-1:0]  addr,
    input  logic [W-1:0]   data_in,
    output logic [W-1:0]   data_out,
    output logic           data_oe,
    input  logic [N*W-1:0] pd_i,
    output logic [N*W-1:0] pd_o,
    output logic [N-1:0]   pd_oe,
    input  logic [N-1:0]   stb_n,
    output logic [N-1:0]   ibf,
    input  logic [N-1:0]   ack_n,
    output logic [N-1:0]   obf_n,
    output logic [N-1:0]   intr
);

    logic wr_n_q, rd_n_q;
    logic wr_pulse, rd_start, rd_end;
    int   addr_i;

    logic [BSR_PORT_W-1:0] bsr_port;
    logic [BSR_BIT_W-1:0]  bsr_bit;
    logic                  bsr_ok;

    logic [CTL_W-1:0] port_ctl [N];
    logic [W-1:0]     port_rd  [N];
    logic [N-1:0]     port_ovr;
    logic [W-1:0]     status;
    logic [W-1:0]     rd_mux;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_n_q <= 1'b1;
            rd_n_q <= 1'b1;
        end else begin
            wr_n_q <= wr_n;
            rd_n_q <= rd_n;
        end
    end

    assign wr_pulse = ~cs_n & ~wr_n & wr_n_q;
    assign rd_start = ~cs_n & ~rd_n & rd_n_q & wr_n;
    assign rd_end   = ~cs_n & rd_n & ~rd_n_q;
    assign addr_i   = int'(addr);

    assign bsr_port = data_in[BSR_PORT_LSB +: BSR_PORT_W];
    assign bsr_bit  = data_in[BSR_BIT_LSB +: BSR_BIT_W];
    assign bsr_ok   = int'(bsr_bit) < W;

    for (genvar p = 0; p < N; p++) begin : g_port
        ppi_port #(.W(W)) u_port (
            .clk        (clk),
            .reset      (reset),
            .pin        (pd_i[p*W +: W]),
            .stb_n      (stb_n[p]),
            .ack_n      (ack_n[p]),
            .ctl_we     (wr_pulse && addr_i == addr_ctl(N, p)),
            .ctl_wdata  (data_in[CTL_W-1:0]),
            .data_we    (wr_pulse && addr_i == addr_data(p)),
            .data_wdata (data_in),
            .bsr_we     (wr_pulse && addr_i == addr_status(N) &&
                         int'(bsr_port) == p && bsr_ok),
            .bsr_bit    (bsr_bit),
            .bsr_val    (data_in[BSR_VAL]),
            .rd_start   (rd_start && addr_i == addr_data(p)),
            .rd_end     (rd_end && addr_i == addr_data(p)),
            .ovr_clr    (rd_end && addr_i == addr_status(N)),
            .ctl        (port_ctl[p]),
            .rd_data    (port_rd[p]),
            .pd_o       (pd_o[p*W +: W]),
            .pd_oe      (pd_oe[p]),
            .ibf        (ibf[p]),
            .obf_n      (obf_n[p]),
            .intr       (intr[p]),
            .ovr        (port_ovr[p])
        );
    end

    always_comb begin
        status = '0;
        for (int p = 0; p < N; p++) begin
            status[ST_PER_PORT*p + ST_IBF]  = ibf[p];
            status[ST_PER_PORT*p + ST_OBF]  = ~obf_n[p];
            status[ST_PER_PORT*p + ST_INTR] = intr[p];
            status[ST_PER_PORT*p + ST_OVR]  = port_ovr[p];
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int p = 0; p < N; p++) begin
            if (addr_i == addr_data(p))   rd_mux = port_rd[p];
            if (addr_i == addr_ctl(N, p)) rd_mux = {{(W-CTL_W){1'b0}}, port_ctl[p]};
        end
        if (addr_i == addr_status(N)) rd_mux = status;
    end

    assign data_oe  = ~reset & ~cs_n & ~rd_n & wr_n;
    assign data_out = data_oe ? rd_mux : '0;

endmodule

// File: tb/tb_ppi_hs.sv
// tb_ppi_hs: directed test-plan steps followed by a randomized operation
// sequence, all checked against a transaction-level model of the PPI.
module tb_ppi_hs;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int AW = $clog2(2*N+1);
    localparam int ST = 2*N;

    logic           clk = 1'b0;
    logic           reset;
    logic           cs_n, rd_n, wr_n;
    logic [AW-1:0]  addr;
    logic [W-1:0]   data_in;
    logic [W-1:0]   data_out;
    logic           data_oe;
    logic [N*W-1:0] pd_i;
    logic [N*W-1:0] pd_o;
    logic [N-1:0]   pd_oe;
    logic [N-1:0]   stb_n;
    logic [N-1:0]   ibf;
    logic [N-1:0]   ack_n;
    logic [N-1:0]   obf_n;
    logic [N-1:0]   intr;

    always #5 clk = ~clk;

    ppi_hs #(.W(W), .N(N), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs_n     (cs_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .pd_i     (pd_i),
        .pd_o     (pd_o),
        .pd_oe    (pd_oe),
        .stb_n    (stb_n),
        .ibf      (ibf),
        .ack_n    (ack_n),
        .obf_n    (obf_n),
        .intr     (intr)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model (transaction level) ----------------
    logic [2:0]   m_ctl   [N];
    logic [W-1:0] m_latch [N];
    logic [W-1:0] m_pin   [N];
    bit           m_ibf   [N];
    bit           m_full  [N];
    bit           m_intr  [N];
    bit           m_ovr   [N];

    function automatic bit is_input(int p);   return m_ctl[p][0]; endfunction
    function automatic bit is_strobed(int p); return m_ctl[p][1]; endfunction
    function automatic bit int_en(int p);     return m_ctl[p][2]; endfunction

    function automatic void m_reset();
        for (int p = 0; p < N; p++) begin
            m_ctl[p]   = 3'b001;
            m_latch[p] = '0;
            m_ibf[p]   = 0;
            m_full[p]  = 0;
            m_intr[p]  = 0;
            m_ovr[p]   = 0;
        end
    endfunction

    function automatic logic [W-1:0] m_read(int a);
        logic [W-1:0] r = '0;
        if (a < N) begin
            r = (is_input(a) && !is_strobed(a)) ? m_pin[a] : m_latch[a];
        end else if (a < 2*N) begin
            r = {{(W-3){1'b0}}, m_ctl[a-N]};
        end else if (a == ST) begin
            for (int p = 0; p < N; p++) begin
                r[4*p]   = m_ibf[p];
                r[4*p+1] = m_full[p];
                r[4*p+2] = m_intr[p];
                r[4*p+3] = m_ovr[p];
            end
        end
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        for (int p = 0; p < N; p++) begin
            check($sformatf("%s pd_o%0d", ctx, p),  pd_o[p*W +: W], m_latch[p]);
            check($sformatf("%s pd_oe%0d", ctx, p), pd_oe[p], !is_input(p));
            check($sformatf("%s ibf%0d", ctx, p),   ibf[p], m_ibf[p]);
            check($sformatf("%s obf_n%0d", ctx, p), obf_n[p], !m_full[p]);
            check($sformatf("%s intr%0d", ctx, p),  intr[p], m_intr[p]);
        end
        check($sformatf("%s data_oe", ctx), data_oe, 1'b0);
    endtask

    // ---------------- bus drivers ----------------
    task automatic bus_write(input int a, input logic [W-1:0] d);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; addr = a[AW-1:0]; data_in = d;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    // Returns read data, plus intr/ibf sampled after the read-start edge.
    task automatic bus_read(input int a, output logic [W-1:0] d, output logic oe,
                            output logic [N-1:0] im, output logic [N-1:0] ib);
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; addr = a[AW-1:0];
        #1;
        d  = data_out;
        oe = data_oe;
        @(negedge clk);
        im = intr;
        ib = ibf;
        rd_n = 1'b1;
        @(negedge clk);
        cs_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- operations: drive DUT and advance model ----------------
    task automatic op_ctl(input int p, input logic [2:0] v);
        bus_write(N + p, {{(W-3){1'b0}}, v});
        m_ctl[p] = v; m_latch[p] = '0; m_ibf[p] = 0;
        m_full[p] = 0; m_intr[p] = 0; m_ovr[p] = 0;
    endtask

    task automatic op_wr(input int p, input logic [W-1:0] d);
        bus_write(p, d);
        if (!is_input(p)) begin
            m_latch[p] = d;
            if (is_strobed(p)) begin
                if (m_full[p]) m_ovr[p] = 1;
                m_full[p] = 1;
                m_intr[p] = 0;
            end
        end
    endtask

    task automatic op_bsr(input int p, input int b, input logic v);
        logic [2:0] fp;
        logic [3:0] fb;
        fp = p[2:0];
        fb = b[3:0];
        bus_write(ST, {fp, fb, v});
        if (p < N && b < W) begin
            if (!is_input(p)) m_latch[p][b] = v;
        end
    endtask

    task automatic op_bad_wr(input int a, input logic [W-1:0] d);
        bus_write(a, d);
    endtask

    task automatic op_strobe(input int p, input logic [W-1:0] d);
        bit old_ibf;
        @(negedge clk);
        pd_i[p*W +: W] = d;
        m_pin[p] = d;
        @(negedge clk);
        stb_n[p] = 1'b0;
        old_ibf = m_ibf[p];
        if (is_input(p) && is_strobed(p)) begin
            if (m_ibf[p]) m_ovr[p] = 1;
            else begin
                m_latch[p] = d;
                m_ibf[p] = 1;
            end
        end
        repeat (2) @(negedge clk);
        check("stb ibf 2clk", ibf[p], old_ibf);
        @(negedge clk);
        check("stb ibf 3clk", ibf[p], m_ibf[p]);
        stb_n[p] = 1'b1;
        if (is_input(p) && is_strobed(p) && int_en(p)) m_intr[p] = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic op_ack(input int p);
        bit old_full;
        @(negedge clk);
        ack_n[p] = 1'b0;
        old_full = m_full[p];
        if (!is_input(p) && is_strobed(p)) m_full[p] = 0;
        repeat (2) @(negedge clk);
        check("ack obf_n 2clk", obf_n[p], !old_full);
        @(negedge clk);
        check("ack obf_n 3clk", obf_n[p], !m_full[p]);
        ack_n[p] = 1'b1;
        if (!is_input(p) && is_strobed(p) && int_en(p)) m_intr[p] = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic op_read(input int a, output logic [W-1:0] d);
        logic [W-1:0] exp_d;
        logic         oe;
        logic [N-1:0] im, ib;
        exp_d = m_read(a);
        bus_read(a, d, oe, im, ib);
        check($sformatf("read data a%0d", a), d, exp_d);
        check("read data_oe", oe, 1'b1);
        if (a < N) begin
            if (is_input(a) && is_strobed(a)) begin
                check("read intr at start", im[a], 1'b0);
                check("read ibf at start", ib[a], m_ibf[a]);
                m_intr[a] = 0;
                m_ibf[a]  = 0;
            end else begin
                check("read intr held", im[a], m_intr[a]);
            end
        end
        if (a == ST) begin
            for (int p = 0; p < N; p++) m_ovr[p] = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        int           op, p, a;

        // ---- clock/reset ----
        reset = 1'b1;
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr = '0; data_in = '0; pd_i = '0;
        stb_n = '1; ack_n = '1;
        for (int i = 0; i < N; i++) m_pin[i] = '0;
        m_reset();
        repeat (3) @(negedge clk);
        check_all("in reset");
        check("reset data_out", data_out, '0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state of every address, including unused ones.
        for (int i = 0; i < (1 << AW); i++) op_read(i, d);
        op_read(N, d);
        check("ctl0 reset value", d, 8'h01);
        op_read(ST, d);
        check("status reset value", d, 8'h00);
        check_all("after reset");

        // ---- port 0, mode 0 output, BSR ----
        op_ctl(0, 3'b000);
        op_wr(0, 8'hBC);
        check("p0 mode0 pd_o", pd_o[7:0], 8'hBC);
        check("p0 pd_oe", pd_oe[0], 1'b1);
        op_bsr(0, 1, 1'b0);
        check("bsr clear bit1", pd_o[7:0], 8'hBC);
        op_bsr(0, 0, 1'b1);
        check("bsr set bit0", pd_o[7:0], 8'hBD);
        check("bsr obf_n untouched", obf_n[0], 1'b1);
        check_all("mode0 out");

        // ---- port 1, mode 1 input with interrupt ----
        op_ctl(1, 3'b111);
        op_strobe(1, 8'h5A);
        check("p1 ibf after stb", ibf[1], 1'b1);
        check("p1 intr after stb", intr[1], 1'b1);
        op_read(1, d);
        check("p1 read latch", d, 8'h5A);
        check("p1 ibf after read", ibf[1], 1'b0);
        check_all("mode1 in");

        // ---- overrun ----
        op_strobe(1, 8'h5A);
        op_strobe(1, 8'h33);
        op_read(ST, d);
        check("status ovr1 set", d[7], 1'b1);
        op_read(ST, d);
        check("status ovr1 cleared", d[7], 1'b0);
        op_read(1, d);
        check("p1 latch kept", d, 8'h5A);
        check_all("overrun");

        // ---- port 0, mode 1 output ----
        op_ctl(0, 3'b110);
        op_wr(0, 8'h67);
        check("p0 obf_n after write", obf_n[0], 1'b0);
        check("p0 pd_o driven", pd_o[7:0], 8'h67);
        op_ack(0);
        check("p0 obf_n after ack", obf_n[0], 1'b1);
        check("p0 intr after ack", intr[0], 1'b1);
        op_wr(0, 8'h12);
        check("p0 intr cleared by write", intr[0], 1'b0);
        check_all("mode1 out");

        // ---- reset in the middle of a handshake ----
        op_ctl(1, 3'b111);
        op_strobe(1, 8'hAA);
        check("p1 ibf before reset", ibf[1], 1'b1);
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; addr = ST[AW-1:0];
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        check_all("async reset");
        check("reset data_oe during read", data_oe, 1'b0);
        check("reset data_out during read", data_out, '0);
        cs_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        op_strobe(1, 8'h77);
        check("mode0 stb no ibf", ibf[1], 1'b0);
        check("mode0 stb no intr", intr[1], 1'b0);
        check_all("post reset");

        // ---- randomized operations ----
        for (int i = 0; i < 120; i++) begin
            op = $urandom_range(0, 7);
            p  = $urandom_range(0, N-1);
            case (op)
                0: op_ctl(p, 3'($urandom_range(0, 7)));
                1: op_wr(p, W'($urandom));
                2: op_bsr($urandom_range(0, 3), $urandom_range(0, 9), 1'($urandom_range(0, 1)));
                3: op_strobe(p, W'($urandom));
                4: op_ack(p);
                5: begin
                    a = $urandom_range(0, (1 << AW) - 1);
                    op_read(a, d);
                end
                6: op_read(ST, d);
                default: op_bad_wr($urandom_range(ST + 1, (1 << AW) - 1), W'($urandom));
            endcase
            check_all("random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
